// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Brief    : Multi-port register file with per-register busy scoreboard.
//            Optional same-cycle write forwarding under REGFILE_SB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 12,
  parameter int AW    = 4,
  parameter int NRD   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NRD*AW-1:0]            ra,
  output logic [NRD*WIDTH-1:0]         rd,
  output logic [NRD-1:0]               rd_busy,
  input  logic                         we0,
  input  logic [AW-1:0]                wa0,
  input  logic [WIDTH-1:0]             wd0,
  input  logic                         we1,
  input  logic [AW-1:0]                wa1,
  input  logic [WIDTH-1:0]             wd1,
  input  logic                         iss_en,
  input  logic [AW-1:0]                iss_addr,
  output logic                         iss_ready,
  output logic [$clog2(DEPTH+1)-1:0]   busy_cnt
);

  localparam int            c_CW    = $clog2(DEPTH+1);
  localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);

  function automatic logic f_in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < c_DEPTH);
  endfunction

  logic [WIDTH-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [c_CW-1:0]  r_cnt;

  logic [DEPTH-1:0] w_wsel0;
  logic [DEPTH-1:0] w_wsel1;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_iss_ready;
  logic             w_iss_acc;
  logic [c_CW-1:0]  w_pop;

  // Out-of-range issue addresses never block the requester.
  assign w_iss_ready = f_in_range(iss_addr) ? ~r_busy[iss_addr] : 1'b1;
  assign w_iss_acc   = iss_en && w_iss_ready;

  genvar j;
  generate
    for (j = 0; j < DEPTH; j++) begin : g_reg
      localparam logic [AW-1:0] c_IDX = AW'(j);
      logic w_set;
      logic w_clr;
      assign w_wsel0[j]    = we0 && (wa0 == c_IDX);
      assign w_wsel1[j]    = we1 && (wa1 == c_IDX);
      assign w_set         = w_iss_acc && (iss_addr == c_IDX);
      assign w_clr         = w_wsel0[j] || w_wsel1[j];
      // An issue landing together with a write keeps the register busy.
      assign w_busy_nxt[j] = w_set ? 1'b1 : (w_clr ? 1'b0 : r_busy[j]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_rf[k] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_wsel1[k])      r_rf[k] <= wd1;
        else if (w_wsel0[k]) r_rf[k] <= wd0;
      end
      r_busy <= w_busy_nxt;
      r_cnt  <= w_pop;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < DEPTH; k++) w_pop = w_pop + c_CW'(r_busy[k]);
  end

  genvar i;
  generate
    for (i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]    w_ra;
      logic             w_inr;
      logic [WIDTH-1:0] w_arr;
      logic             w_abusy;
      assign w_ra    = ra[i*AW +: AW];
      assign w_inr   = f_in_range(w_ra);
      assign w_arr   = w_inr ? r_rf[w_ra] : '0;
      assign w_abusy = w_inr ? r_busy[w_ra] : 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
      logic w_hit0;
      logic w_hit1;
      assign w_hit0 = w_inr && we0 && (wa0 == w_ra);
      assign w_hit1 = w_inr && we1 && (wa1 == w_ra);
      assign rd[i*WIDTH +: WIDTH] = w_hit1 ? wd1 : (w_hit0 ? wd0 : w_arr);
      assign rd_busy[i]           = (w_hit0 || w_hit1) ? 1'b0 : w_abusy;
`else
      assign rd[i*WIDTH +: WIDTH] = w_arr;
      assign rd_busy[i]           = w_abusy;
`endif
    end
  endgenerate

  assign iss_ready = w_iss_ready;
  assign busy_cnt  = r_cnt;

endmodule

`default_nettype wire
